// File: rtl/sseg_frame_arbiter.sv
// Round-robin arbiter sharing a 4-digit seven-segment display between two frame producers,
// with a minimum on-screen hold time per granted frame and fully registered display outputs.
module sseg_frame_arbiter #(
    parameter int unsigned HOLD_CYCLES = 25_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [15:0] req0_digits,
    input  logic        req0_sign,
    input  logic [15:0] req1_digits,
    input  logic        req1_sign,
    output logic [3:0]  bcd0,
    output logic [3:0]  bcd1,
    output logic [3:0]  bcd2,
    output logic [3:0]  bcd3,
    output logic        sign,
    output logic        disp_valid,
    output logic        owner
);

    localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2,
        SHOW = 2'd3
    } state_t;

    state_t           state, state_n;
    logic             grant, grant_n;
    logic             last_owner;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             capture;
    logic             cap_idx;
    logic [15:0]      cap_digits;
    logic             cap_sign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            grant <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            grant <= grant_n;
            cnt   <= cnt_n;
        end
    end

    // req_ready is derived only from registered state so it never loops back through req_valid.
    always_comb begin
        state_n   = state;
        grant_n   = grant;
        cnt_n     = cnt;
        capture   = 1'b0;
        cap_idx   = owner;
        req_ready = '0;
        unique case (state)
            IDLE: begin
                if (|req_valid) begin
                    grant_n = (req_valid == 2'b11) ? ~last_owner : req_valid[1];
                    state_n = LOAD;
                end
            end
            LOAD: begin
                req_ready[grant] = 1'b1;
                if (req_valid[grant]) begin
                    capture = 1'b1;
                    cap_idx = grant;
                    cnt_n   = HOLD_LOAD;
                    state_n = HOLD;
                end else begin
                    state_n = disp_valid ? SHOW : IDLE;
                end
            end
            HOLD: begin
                req_ready[owner] = 1'b1;
                capture          = req_valid[owner];
                if (cnt == '0) begin
                    if (req_valid[~owner]) begin
                        grant_n = ~owner;
                        state_n = LOAD;
                    end else begin
                        state_n = SHOW;
                    end
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            SHOW: begin
                req_ready[owner] = 1'b1;
                capture          = req_valid[owner];
                if (req_valid[~owner]) begin
                    grant_n = ~owner;
                    state_n = LOAD;
                end
            end
            default: state_n = IDLE;
        endcase
        // A transfer coinciding with clear is dropped.
        if (clear) begin
            state_n = IDLE;
            capture = 1'b0;
            cnt_n   = '0;
        end
    end

    assign cap_digits = cap_idx ? req1_digits : req0_digits;
    assign cap_sign   = cap_idx ? req1_sign   : req0_sign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd0       <= '0;
            bcd1       <= '0;
            bcd2       <= '0;
            bcd3       <= '0;
            sign       <= 1'b0;
            disp_valid <= 1'b0;
            owner      <= 1'b0;
            last_owner <= 1'b1;
        end else if (clear) begin
            bcd0       <= '0;
            bcd1       <= '0;
            bcd2       <= '0;
            bcd3       <= '0;
            sign       <= 1'b0;
            disp_valid <= 1'b0;
        end else if (capture) begin
            bcd0       <= cap_digits[3:0];
            bcd1       <= cap_digits[7:4];
            bcd2       <= cap_digits[11:8];
            bcd3       <= cap_digits[15:12];
            sign       <= cap_sign;
            disp_valid <= 1'b1;
            owner      <= cap_idx;
            last_owner <= cap_idx;
        end
    end

endmodule

// File: tb/tb_sseg_frame_arbiter.sv
// Scoreboard bench for sseg_frame_arbiter: expected display frames are queued by the stimulus
// and popped by a monitor whenever the displayed tuple changes; ready timing is checked inline.
module tb_sseg_frame_arbiter;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req0_digits;
    logic        req0_sign;
    logic [15:0] req1_digits;
    logic        req1_sign;
    logic [3:0]  bcd0, bcd1, bcd2, bcd3;
    logic        sign;
    logic        disp_valid;
    logic        owner;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [18:0] exp_q[$];
    logic [18:0] disp;
    logic [18:0] prev;
    logic        mon_en = 1'b0;

    sseg_frame_arbiter #(.HOLD_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req0_digits (req0_digits),
        .req0_sign   (req0_sign),
        .req1_digits (req1_digits),
        .req1_sign   (req1_sign),
        .bcd0        (bcd0),
        .bcd1        (bcd1),
        .bcd2        (bcd2),
        .bcd3        (bcd3),
        .sign        (sign),
        .disp_valid  (disp_valid),
        .owner       (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tuple layout: {disp_valid, owner, sign, d3, d2, d1, d0}
    assign disp = {disp_valid, owner, sign, bcd3, bcd2, bcd1, bcd0};

    function automatic logic [18:0] frame(input logic dv, input logic ow, input logic sg,
                                          input logic [15:0] d);
        return {dv, ow, sg, d};
    endfunction

    always @(negedge clk) begin
        logic [18:0] e;
        if (mon_en && disp !== prev) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_update: got %h, expected no change", disp);
            end else begin
                e = exp_q.pop_front();
                if (disp !== e) begin
                    errors++;
                    $display("FAIL display_frame: got %h, expected %h", disp, e);
                end
            end
            prev = disp;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rdy(input string nm, input logic [1:0] exp);
        checks++;
        if (req_ready !== exp) begin
            errors++;
            $display("FAIL %s: req_ready=%b, expected %b", nm, req_ready, exp);
        end
    endtask

    task automatic chk_disp(input string nm, input logic [18:0] exp);
        checks++;
        if (disp !== exp) begin
            errors++;
            $display("FAIL %s: display=%h, expected %h", nm, disp, exp);
        end
    endtask

    initial begin
        rst_n       = 1'b1;
        clear       = 1'b0;
        req_valid   = 2'b00;
        req0_digits = '0;
        req0_sign   = 1'b0;
        req1_digits = '0;
        req1_sign   = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_disp("reset_display", '0);
        chk_rdy("reset_ready", 2'b00);
        step();
        step();
        #3 rst_n = 1'b1;
        prev   = '0;
        mon_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk_rdy("idle_ready", 2'b00);
            chk_disp("idle_display", '0);
        end

        // Single requester, hold expiry into SHOW.
        req_valid   = 2'b01;
        req0_digits = 16'h1234;
        req0_sign   = 1'b1;
        step(); chk_rdy("a_load", 2'b01);
        exp_q.push_back(frame(1'b1, 1'b0, 1'b1, 16'h1234));
        step(); chk_rdy("a_xfer", 2'b01);
        req_valid = 2'b00;
        for (int i = 0; i < 5; i++) begin
            step(); chk_rdy("a_hold_show", 2'b01);
        end

        // Async reset between edges restores last_owner=1.
        #3 rst_n = 1'b0;
        exp_q.push_back('0);
        #1 chk_rdy("rst1_ready", 2'b00);
        chk_disp("rst1_display", '0);
        step();
        step();
        #3 rst_n = 1'b1;

        // Tie from IDLE, owner update mid-hold, switch at original expiry.
        step();
        req_valid   = 2'b11;
        req0_digits = 16'hABCD;
        req0_sign   = 1'b0;
        req1_digits = 16'h0909;
        req1_sign   = 1'b1;
        step(); chk_rdy("tie_grant0", 2'b01);
        exp_q.push_back(frame(1'b1, 1'b0, 1'b0, 16'hABCD));
        step(); chk_rdy("b_xfer", 2'b01);
        req_valid = 2'b10;
        step(); chk_rdy("b_hold1", 2'b01);
        req_valid   = 2'b11;
        req0_digits = 16'h0005;
        exp_q.push_back(frame(1'b1, 1'b0, 1'b0, 16'h0005));
        step(); chk_rdy("b_update", 2'b01);
        req_valid = 2'b10;
        step(); chk_rdy("b_hold3", 2'b01);
        step(); chk_rdy("grant_at_expiry", 2'b10);
        exp_q.push_back(frame(1'b1, 1'b1, 1'b1, 16'h0909));
        step(); chk_rdy("c_xfer", 2'b10);
        req_valid   = 2'b01;
        req0_digits = 16'h0F0E;
        req0_sign   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); chk_rdy("c_hold", 2'b10);
        end
        step(); chk_rdy("c_switch", 2'b01);
        exp_q.push_back(frame(1'b1, 1'b0, 1'b1, 16'h0F0E));
        step(); chk_rdy("d_xfer", 2'b01);

        // Clear during HOLD with a live transfer: frame dropped, display blanked.
        req0_digits = 16'h7777;
        req0_sign   = 1'b0;
        clear       = 1'b1;
        exp_q.push_back(frame(1'b0, 1'b0, 1'b0, 16'h0000));
        step(); chk_rdy("clear_ready", 2'b00);
        clear       = 1'b0;
        req_valid   = 2'b11;
        req1_digits = 16'h2468;
        req1_sign   = 1'b0;
        step(); chk_rdy("tie_after_clear", 2'b10);
        exp_q.push_back(frame(1'b1, 1'b1, 1'b0, 16'h2468));
        step(); chk_rdy("e_xfer", 2'b10);
        req_valid = 2'b00;
        for (int i = 0; i < 4; i++) begin
            step(); chk_rdy("e_hold_show", 2'b10);
        end

        // SHOW -> LOAD, then LOAD abandoned falls back to SHOW.
        req_valid   = 2'b01;
        req0_digits = 16'h5A5A;
        step(); chk_rdy("show_to_load", 2'b01);
        req_valid = 2'b00;
        step(); chk_rdy("load_drop_to_show", 2'b10);
        req_valid   = 2'b10;
        req1_digits = 16'h1357;
        req1_sign   = 1'b1;
        exp_q.push_back(frame(1'b1, 1'b1, 1'b1, 16'h1357));
        step(); chk_rdy("show_update", 2'b10);
        req_valid   = 2'b01;
        req0_digits = 16'h5555;
        step(); chk_rdy("f_load", 2'b01);

        // Async reset mid-LOAD.
        #2 rst_n = 1'b0;
        exp_q.push_back('0);
        #1 chk_rdy("rst2_ready", 2'b00);
        chk_disp("rst2_display", '0);
        req_valid   = 2'b11;
        req0_digits = 16'h0001;
        req0_sign   = 1'b0;
        req1_digits = 16'h0002;
        req1_sign   = 1'b1;
        step();
        step();
        #3 rst_n = 1'b1;
        chk_rdy("rst2_release", 2'b00);
        step(); chk_rdy("post_reset_tie", 2'b01);
        exp_q.push_back(frame(1'b1, 1'b0, 1'b0, 16'h0001));
        step(); chk_rdy("g_xfer", 2'b01);
        req_valid = 2'b00;
        repeat (6) step();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d frames left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
